uart_tx_core: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_tick.sv | 38 +++
 rtl/uart_tx_core.sv | 158 +++++++++++++++
 tb/tb_uart_tx_core.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and baud defaults.
// The receiver imports the same package.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // 100 MHz system clock / 115200 baud
  localparam int CLKS_PER_BIT_115200_100MHZ = 868;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic data_xor, input int mode);
    return (mode == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: while enabled, emits a one-cycle tick every CLKS_PER_BIT
// clocks. Held at zero while disabled, so every enable rise restarts a full period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200_100MHZ
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count 0..CLKS_PER_BIT-1 and wrap; clear whenever disabled.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!en_i || (cnt_q == CNT_MAX)) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: one-entry holding register behind a valid/ready handshake
// feeding a start/data/parity/stop serialiser. A byte queued during a frame
// starts the next frame straight out of the stop bit(s), with no idle gap.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200_100MHZ,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                 CLK_100MHz,
  input  logic                 Reset,
  input  logic [DATA_BITS-1:0] TxData,
  input  logic                 TxValid,
  output logic                 TxReady,
  output logic                 Tx,
  output logic                 TxBusy
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_e          state_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 ready_q;
  logic                 full_q, full_d;
  logic                 par_q;
  logic [2:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] hold_q;
  logic [DATA_BITS-1:0] shift_q;

  logic tick;
  logic accept;
  logic frame_end;
  logic load;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i (CLK_100MHz),
    .rst_i (Reset),
    .en_i  (state_q != ST_IDLE),
    .tick_o(tick)
  );

  assign accept    = TxValid && ready_q;
  assign frame_end = (state_q == ST_STOP) && tick && (bit_cnt_q == LAST_STOP);
  // The holding register drains into the shifter either from IDLE or
  // directly at the end of the last stop bit (back-to-back frames).
  assign load      = full_q && ((state_q == ST_IDLE) || frame_end);

  // Holding-register occupancy: accept and load are mutually exclusive
  // because accept needs the register empty and load needs it full.
  always_comb begin
    full_d = full_q;
    if (load)   full_d = 1'b0;
    if (accept) full_d = 1'b1;
  end

  // Frame sequencer with registered line, busy and ready outputs.
  always_ff @(posedge CLK_100MHz) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      full_q    <= 1'b0;
      ready_q   <= 1'b1;
      bit_cnt_q <= 3'd0;
    end else begin
      full_q  <= full_d;
      ready_q <= ~full_d;
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            state_q   <= ST_START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            bit_cnt_q <= 3'd0;
          end
        end
        ST_START: begin
          if (tick) begin
            state_q   <= ST_DATA;
            tx_q      <= shift_q[0];
            bit_cnt_q <= 3'd0;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_q <= 3'd0;
              if (PARITY != PARITY_NONE) begin
                state_q <= ST_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= ST_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              tx_q      <= shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state_q   <= ST_STOP;
            tx_q      <= 1'b1;
            bit_cnt_q <= 3'd0;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (bit_cnt_q == LAST_STOP) begin
              bit_cnt_q <= 3'd0;
              if (full_q) begin
                state_q <= ST_START;
                tx_q    <= 1'b0;
              end else begin
                state_q <= ST_IDLE;
                tx_q    <= 1'b1;
                busy_q  <= 1'b0;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Data path: capture on accept, move to the shifter on load (parity is
  // computed once per byte here), shift right as each data bit completes.
  always_ff @(posedge CLK_100MHz) begin
    if (accept) begin
      hold_q <= TxData;
    end
    if (load) begin
      shift_q <= hold_q;
      par_q   <= parity_bit(^hold_q, PARITY);
    end else if ((state_q == ST_DATA) && tick) begin
      shift_q <= shift_q >> 1;
    end
  end

  assign TxReady = ready_q;
  assign Tx      = tx_q;
  assign TxBusy  = busy_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: four instances (8N1, 8E1, 8O1, 8N2) at 4 clocks/bit.
// Expected line waveforms and decoded bytes come from the frame rules
// (start, LSB-first data, parity, stop) built up as bit queues.
module tb_uart_tx_core;

  localparam int CPB = 4;
  localparam int ND  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] data  [ND];
  logic       valid [ND];
  logic       ready [ND];
  logic       tx    [ND];
  logic       busy  [ND];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .CLK_100MHz(clk), .Reset(rst), .TxData(data[0]), .TxValid(valid[0]),
    .TxReady(ready[0]), .Tx(tx[0]), .TxBusy(busy[0]));
  uart_tx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .CLK_100MHz(clk), .Reset(rst), .TxData(data[1]), .TxValid(valid[1]),
    .TxReady(ready[1]), .Tx(tx[1]), .TxBusy(busy[1]));
  uart_tx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .CLK_100MHz(clk), .Reset(rst), .TxData(data[2]), .TxValid(valid[2]),
    .TxReady(ready[2]), .Tx(tx[2]), .TxBusy(busy[2]));
  uart_tx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .CLK_100MHz(clk), .Reset(rst), .TxData(data[3]), .TxValid(valid[3]),
    .TxReady(ready[3]), .Tx(tx[3]), .TxBusy(busy[3]));

  function automatic int par_of(input int k);
    case (k)
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int stop_of(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected line levels, one entry per bit-time.
  bit wave_q[$];
  int acc_q[$];
  logic par_seen;
  int   busy_seen;

  task automatic add_frame(input int k, input logic [7:0] b);
    wave_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) wave_q.push_back(b[i]);
    if (par_of(k) == 2) wave_q.push_back(^b);
    else if (par_of(k) == 1) wave_q.push_back(~^b);
    for (int i = 0; i < stop_of(k); i++) wave_q.push_back(1'b1);
  endtask

  // Offer bytes in order; valid stays high between bytes when maxgap is 0.
  task automatic push_bytes(input int k, input logic [7:0] bytes[$], input int maxgap);
    for (int i = 0; i < bytes.size(); i++) begin
      int w;
      w = 0;
      if (maxgap > 0) begin
        @(negedge clk);
        valid[k] = 1'b0;
        repeat ($urandom_range(0, maxgap)) @(negedge clk);
      end
      @(negedge clk);
      data[k]  = bytes[i];
      valid[k] = 1'b1;
      while (ready[k] !== 1'b1 && w < 2000) begin
        @(negedge clk);
        w++;
      end
      if (w >= 2000) begin
        chk("accept_wait", 32'(w), 0);
        valid[k] = 1'b0;
        return;
      end
      @(posedge clk);
      acc_q.push_back(cyc);
    end
    @(negedge clk);
    valid[k] = 1'b0;
    data[k]  = 8'($urandom);
  endtask

  // Compare the line against wave_q cycle by cycle. With exact=1 the caller
  // is already at the negedge of the first start-bit cycle.
  task automatic check_wave(input int k, input bit exact);
    int c;
    int L;
    L = wave_q.size() * CPB;
    c = 0;
    busy_seen = 0;
    par_seen = 1'bx;
    if (!exact) begin
      int w;
      w = 0;
      while (tx[k] !== 1'b0 && w < 3000) begin
        @(negedge clk);
        w++;
      end
      if (w >= 3000) begin
        chk("wave_start_wait", 32'(w), 0);
        return;
      end
    end
    while (busy[k] === 1'b1 && c < 2000) begin
      if (c < L) chk("tx_bit", {31'd0, tx[k]}, {31'd0, wave_q[c / CPB]});
      if (c == 9 * CPB + 1) par_seen = tx[k];
      busy_seen++;
      c++;
      @(negedge clk);
    end
    chk("tx_idle_after", {31'd0, tx[k]}, 1);
    chk("busy_len", 32'(busy_seen), 32'(L));
  endtask

  task automatic send_one(input int k, input logic [7:0] d);
    @(negedge clk);
    chk("ready_idle", {31'd0, ready[k]}, 1);
    data[k]  = d;
    valid[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid[k] = 1'b0;
    data[k]  = ~d;
    chk("tx_before_start", {31'd0, tx[k]}, 1);
    chk("ready_drop", {31'd0, ready[k]}, 0);
    @(negedge clk);
    check_wave(k, 1'b1);
  endtask

  // Decode one frame by mid-bit sampling; ok clears on a bad start/parity/stop.
  task automatic rx_frame(input int k, output logic [7:0] b, output bit ok);
    int w;
    logic [7:0] r;
    w = 0;
    ok = 1'b1;
    r = 8'h00;
    @(negedge clk);
    while (tx[k] !== 1'b0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) begin
      ok = 1'b0;
      b = 8'h00;
      return;
    end
    @(negedge clk);
    if (tx[k] !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      r[i] = tx[k];
    end
    if (par_of(k) != 0) begin
      repeat (CPB) @(negedge clk);
      if (tx[k] !== ((par_of(k) == 2) ? ^r : ~^r)) ok = 1'b0;
    end
    for (int s = 0; s < stop_of(k); s++) begin
      repeat (CPB) @(negedge clk);
      if (tx[k] !== 1'b1) ok = 1'b0;
    end
    b = r;
  endtask

  typedef struct {
    int         k;
    logic [7:0] d;
    logic       exp_par;
    int         exp_bits;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[5];
    logic [7:0] bytes[$];
    logic [7:0] rb;
    bit         ok;
    int         lows;

    tbl[0] = '{k: 0, d: 8'hA5, exp_par: 1'b0, exp_bits: 10};
    tbl[1] = '{k: 1, d: 8'h07, exp_par: 1'b1, exp_bits: 11};
    tbl[2] = '{k: 2, d: 8'h07, exp_par: 1'b0, exp_bits: 11};
    tbl[3] = '{k: 1, d: 8'h03, exp_par: 1'b0, exp_bits: 11};
    tbl[4] = '{k: 3, d: 8'h55, exp_par: 1'b0, exp_bits: 11};

    rst = 1'b1;
    for (int k = 0; k < ND; k++) begin
      valid[k] = 1'b0;
      data[k]  = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < ND; k++) begin
      chk("reset_tx", {31'd0, tx[k]}, 1);
      chk("reset_ready", {31'd0, ready[k]}, 1);
      chk("reset_busy", {31'd0, busy[k]}, 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Single frames from idle: exact latency, bit pattern, parity, length.
    for (int i = 0; i < 5; i++) begin
      wave_q.delete();
      add_frame(tbl[i].k, tbl[i].d);
      send_one(tbl[i].k, tbl[i].d);
      if (par_of(tbl[i].k) != 0) chk("parity_bit", {31'd0, par_seen}, {31'd0, tbl[i].exp_par});
      chk("frame_len", 32'(busy_seen), 32'(tbl[i].exp_bits * CPB));
    end

    // Back-to-back with valid held high: 0x00 then 0xFF, no idle gap.
    wave_q.delete();
    acc_q.delete();
    add_frame(0, 8'h00);
    add_frame(0, 8'hFF);
    bytes = '{8'h00, 8'hFF};
    fork
      push_bytes(0, bytes, 0);
      check_wave(0, 1'b0);
    join
    chk("b2b_accepts", 32'(acc_q.size()), 2);
    if (acc_q.size() == 2) chk("b2b_ready_gap", 32'(acc_q[1] - acc_q[0]), 2);

    // Backpressure: three random bytes offered continuously on every config.
    for (int k = 0; k < ND; k++) begin
      int flen;
      flen = 1 + 8 + ((par_of(k) != 0) ? 1 : 0) + stop_of(k);
      wave_q.delete();
      acc_q.delete();
      bytes.delete();
      for (int i = 0; i < 3; i++) begin
        bytes.push_back(8'($urandom));
        add_frame(k, bytes[i]);
      end
      fork
        push_bytes(k, bytes, 0);
        check_wave(k, 1'b0);
      join
      chk("bp_accepts", 32'(acc_q.size()), 3);
      if (acc_q.size() == 3) begin
        chk("bp_gap1", 32'(acc_q[1] - acc_q[0]), 2);
        chk("bp_gap2", 32'(acc_q[2] - acc_q[0]), 32'(2 + flen * CPB));
      end
    end

    // Random bytes with random idle gaps, checked by a frame decoder.
    for (int k = 0; k < ND; k++) begin
      bytes.delete();
      acc_q.delete();
      for (int i = 0; i < 5; i++) bytes.push_back(8'($urandom));
      fork
        push_bytes(k, bytes, 6);
        begin
          for (int i = 0; i < 5; i++) begin
            rx_frame(k, rb, ok);
            chk("rx_frame_ok", {31'd0, ok}, 1);
            chk("rx_byte", {24'd0, rb}, {24'd0, bytes[i]});
          end
        end
      join
      repeat (2 * CPB) @(negedge clk);
    end

    // Reset during data bit 3 with a second byte queued.
    @(negedge clk);
    data[0]  = 8'h3C;
    valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data[0] = 8'hC3;
    lows = 0;
    while (ready[0] !== 1'b1 && lows < 50) begin
      @(negedge clk);
      lows++;
    end
    @(posedge clk);
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (16) @(negedge clk);
    chk("rst_queued_ready", {31'd0, ready[0]}, 0);
    chk("rst_midframe_busy", {31'd0, busy[0]}, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx[0]}, 1);
    chk("rst_ready", {31'd0, ready[0]}, 1);
    chk("rst_busy", {31'd0, busy[0]}, 0);
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) lows++;
    end
    chk("no_queued_frame", 32'(lows), 0);
    wave_q.delete();
    add_frame(0, 8'h81);
    send_one(0, 8'h81);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
